// File: rtl/rvdff_pkg.sv
// Shared defaults and helpers for the rvdff elastic pipeline family.
package rvdff_pkg;

  localparam int RVDFF_DEF_WIDTH = 28;
  localparam int RVDFF_DEF_DEPTH = 2;

  // Bits needed to hold a count of 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rvdff_pipe_if.sv
// Producer/consumer handshake bundle for rvdff_pipe; master drives inputs,
// slave is the pipeline itself.
interface rvdff_pipe_if
  import rvdff_pkg::*;
#(
  parameter int WIDTH = RVDFF_DEF_WIDTH
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

  modport master (
    output flush,
    output in_valid,
    output din,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  din,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout
  );

endinterface

// File: rtl/rvdff_pipe_stage.sv
// One valid/data register pair of the elastic pipeline. Data is only written
// for valid loads so bubbles and flushes leave the payload flops untouched.
module rvdff_pipe_stage #(
  parameter int               WIDTH     = 28,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             vld_d,
  input  logic [WIDTH-1:0] dat_d,
  output logic             vld_q,
  output logic [WIDTH-1:0] dat_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= RESET_VAL;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= vld_d;
      if (vld_d) begin
        dat_q <= dat_d;
      end
    end
  end

endmodule

// File: rtl/rvdff_pipe.sv
// Parametrised elastic pipeline register with valid/ready handshake, bubble
// collapse and flush. Define RVDFF_PIPE_OCC_EN to add the occ/full outputs.
module rvdff_pipe
  import rvdff_pkg::*;
#(
  parameter int               WIDTH     = RVDFF_DEF_WIDTH,
  parameter int               DEPTH     = RVDFF_DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef RVDFF_PIPE_OCC_EN
  output logic [occ_width(DEPTH)-1:0]  occ,
  output logic                         full,
`endif
  rvdff_pipe_if.slave                  bus
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] vld_in;
  logic [WIDTH-1:0] dat_q  [DEPTH];
  logic [WIDTH-1:0] dat_in [DEPTH];

  assign bus.in_ready  = rdy[0] & ~bus.flush;
  assign bus.out_valid = vld_q[DEPTH-1];
  assign bus.dout      = dat_q[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Unrolled ready chain: a stage can move unless it and everything
    // downstream of it is occupied while the consumer stalls.
    assign rdy[i] = bus.out_ready | ~(&vld_q[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign vld_in[i] = bus.in_valid & bus.in_ready;
      assign dat_in[i] = bus.din;
    end else begin : g_body
      assign vld_in[i] = vld_q[i-1];
      assign dat_in[i] = dat_q[i-1];
    end

    rvdff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .load  (rdy[i]),
      .vld_d (vld_in[i]),
      .dat_d (dat_in[i]),
      .vld_q (vld_q[i]),
      .dat_q (dat_q[i])
    );
  end

`ifdef RVDFF_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic [DEPTH-1:0] vld_nxt;
  logic [OW-1:0]    occ_d;
  logic [OW-1:0]    occ_q;

  // Count the valid vector the stages will hold after this edge.
  always_comb begin
    vld_nxt = vld_q;
    occ_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush) begin
        vld_nxt[i] = 1'b0;
      end else if (rdy[i]) begin
        vld_nxt[i] = vld_in[i];
      end
      occ_d = occ_d + OW'(vld_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign full = (occ_q == OW'(DEPTH));
`endif

endmodule
